cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 4, SHALL set the unified-memory access latency in cycles (legal 2..15).
REQ-002 Parameter ADDR_W, default 14, SHALL set the line address width (16-bit word address, 4-word line).
REQ-003 Parameter LINE_W, default 64, SHALL set the cache line width in bits.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_rd_req  input  1  SHALL be the I-cache miss line-fill request.
REQ-007 i_addr  input  ADDR_W  SHALL be the I-cache fill line address.
REQ-008 d_rd_req  input  1  SHALL be the D-cache miss line-fill request.
REQ-009 d_wr_req  input  1  SHALL be the D-cache dirty-line writeback request.
REQ-010 d_rd_addr, d_wr_addr  input  ADDR_W each  SHALL be the D-cache fill and writeback line addresses.
REQ-011 d_wdata  input  LINE_W  SHALL be the writeback line.
REQ-012 i_ack, d_ack  output  1 each  SHALL be one-cycle completion pulses to the owning cache.
REQ-013 rd_line  output  LINE_W  SHALL be the registered fill data, valid in the i_ack/d_ack fill cycle.
REQ-014 mem_re, mem_we  output  1 each  SHALL be the unified-memory read and write strobes.
REQ-015 mem_addr  output  ADDR_W; mem_wdata  output  LINE_W; mem_rdata  input  LINE_W.
REQ-016 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and DONE; arbitration SHALL occur only in IDLE.
REQ-018 Fixed priority in IDLE SHALL be d_wr_req > d_rd_req > i_rd_req.
REQ-019 On a grant, the FSM SHALL latch the owner, the operation, the address and (for a write) d_wdata, then enter ACCESS.
REQ-020 In ACCESS, mem_re or mem_we SHALL be held high with stable mem_addr/mem_wdata for exactly MEM_LAT cycles, counted by a 4-bit counter cleared on entry.
REQ-021 In the final ACCESS cycle, reads SHALL capture mem_rdata into rd_line, and the FSM SHALL go to DONE.
REQ-022 DONE SHALL pulse the owner's ack for one cycle, then return to IDLE; the two acks SHALL never be high together.
REQ-023 Latency: a request seen in IDLE at cycle T SHALL drive a strobe in T+1..T+MEM_LAT and ack at T+MEM_LAT+1.
REQ-024 Requesters hold req and address stable until ack and drop req the cycle after ack; the arbiter SHALL complete a granted access even if its req drops early.
REQ-025 A request arriving during ACCESS/DONE SHALL wait; simultaneous d_wr_req and d_rd_req SHALL serve the writeback first, so the fill reads post-writeback memory.
REQ-026 rd_line SHALL hold its last value after a write access and while idle.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, counter 0, i_ack=d_ack=mem_re=mem_we=busy=0, mem_addr=0, mem_wdata=0 and rd_line=0.
REQ-028 Reset mid-ACCESS SHALL abandon the access with no ack; requesters re-request after reset.

Configuration
REQ-029 With MEM_ARB_RR_EN defined, ties between the I side and the D side SHALL alternate, using a last-winner flop that resets to D-side; D-internal order stays writeback first.
REQ-030 Without MEM_ARB_RR_EN, REQ-018 fixed priority SHALL apply, and the last-winner flop SHALL not exist.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the owner/operation enum and the default MEM_LAT/ADDR_W/LINE_W constants.
REQ-032 The arbitration decision SHALL be one combinational sub-module, mem_arb_pick; the FSM, counter and datapath registers stay in the top.

Verification (MEM_LAT=4)
REQ-033 Only i_rd_req at T=10 with i_addr=0x0123 and mem_rdata=0xDEADBEEF_CAFEF00D -> mem_re high at T=11..14 with mem_addr=0x0123; i_ack at T=15 with rd_line=0xDEADBEEF_CAFEF00D.
REQ-034 i_rd_req and d_rd_req together in IDLE -> D fill served first (d_ack at T+5), then IDLE for one cycle, then I fill (i_ack at T+11).
REQ-035 d_wr_req (addr 0x0040, data 0x1111_2222_3333_4444) with d_rd_req (addr 0x0040) -> mem_we for 4 cycles and d_ack, then a read returning 0x1111_2222_3333_4444.
REQ-036 With MEM_ARB_RR_EN, continuous i_rd_req and d_rd_req -> grants alternate I, D, I, D; without it -> D is served every time while asserted.
REQ-037 rst_n low during the 2nd ACCESS cycle -> all outputs 0 immediately, no ack; a fresh request after release is served with the REQ-023 latency.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and default sizing for the cache/unified-memory arbiter.
package cache_mem_arbiter_pkg;

    localparam int unsigned DefMemLat = 4;
    localparam int unsigned DefAddrW  = 14;
    localparam int unsigned DefLineW  = 64;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    // Owner and operation are folded together: the D side may read or write.
    typedef enum logic [1:0] {
        OpNone,
        OpIRd,
        OpDRd,
        OpDWr
    } grant_e;

endpackage

// File: rtl/cache_mem_arbiter_pick.sv
// Combinational grant selection; MEM_ARB_RR_EN alternates I/D ties via last_d.
module mem_arb_pick
    import cache_mem_arbiter_pkg::*;
(
    input  logic   i_rd_req,
    input  logic   d_rd_req,
    input  logic   d_wr_req,
`ifdef MEM_ARB_RR_EN
    input  logic   last_d,
`endif
    output grant_e grant
);

    always_comb begin
        grant = OpNone;
        if (d_wr_req) begin
            grant = OpDWr;
        end else if (d_rd_req) begin
            grant = OpDRd;
        end else if (i_rd_req) begin
            grant = OpIRd;
        end
`ifdef MEM_ARB_RR_EN
        // The I side takes an I/D tie whenever the D side won last.
        if (i_rd_req && (d_wr_req || d_rd_req) && last_d) begin
            grant = OpIRd;
        end
`endif
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// I/D cache line-fill and writeback arbiter for a fixed-latency unified memory.
// Define MEM_ARB_RR_EN to alternate I-side/D-side ties instead of fixed D priority.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = DefMemLat,
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned LINE_W  = DefLineW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_rd_req,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_rd_addr,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              i_ack,
    output logic              d_ack,
    output logic [LINE_W-1:0] rd_line,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [3:0] LastCnt = 4'(MEM_LAT - 1);

    state_e              state_q, state_d;
    grant_e              op_q, op_d;
    grant_e              grant;
    logic [3:0]          cnt_q, cnt_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   rd_line_q, rd_line_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
`ifdef MEM_ARB_RR_EN
    logic                last_d_q, last_d_d;
`endif

    mem_arb_pick u_pick (
        .i_rd_req (i_rd_req),
        .d_rd_req (d_rd_req),
        .d_wr_req (d_wr_req),
`ifdef MEM_ARB_RR_EN
        .last_d   (last_d_q),
`endif
        .grant    (grant)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        mem_re_d  = mem_re_q;
        mem_we_d  = mem_we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_line_d = rd_line_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d_d  = last_d_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant != OpNone) begin
                    op_d    = grant;
                    cnt_d   = 4'd0;
                    state_d = StAccess;
`ifdef MEM_ARB_RR_EN
                    last_d_d = (grant != OpIRd);
`endif
                    case (grant)
                        OpDWr: begin
                            mem_we_d = 1'b1;
                            addr_d   = d_wr_addr;
                            wdata_d  = d_wdata;
                        end
                        OpDRd: begin
                            mem_re_d = 1'b1;
                            addr_d   = d_rd_addr;
                        end
                        default: begin
                            mem_re_d = 1'b1;
                            addr_d   = i_addr;
                        end
                    endcase
                end
            end
            StAccess: begin
                if (cnt_q == LastCnt) begin
                    // Strobes drop and the ack is armed so it is visible during DONE.
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (op_q != OpDWr) begin
                        rd_line_d = mem_rdata;
                    end
                    i_ack_d = (op_q == OpIRd);
                    d_ack_d = (op_q != OpIRd);
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= OpNone;
            cnt_q     <= 4'd0;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_line_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            mem_re_q  <= mem_re_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_line_q <= rd_line_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
`ifdef MEM_ARB_RR_EN
            last_d_q  <= last_d_d;
`endif
        end
    end

    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign rd_line   = rd_line_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != StIdle);

endmodule
